// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR front end: sample/coefficient formats,
// tap counts and the MAC phase encoding.
package fir_pkg;

  localparam int NBLK  = 5;
  localparam int NPH   = 3;
  localparam int NCOEF = NBLK * NPH;
  localparam int NTAPS = 2 * NCOEF - 1;

  typedef struct packed {
    logic signed [23:0] I;
    logic signed [23:0] Q;
  } Samp;

  typedef struct packed {
    logic signed [26:0] I;
    logic signed [26:0] Q;
  } Coef;

  typedef enum logic [1:0] {
    IDLE,
    PH0,
    PH1,
    PH2
  } Phase;

  // One in-flight MAC phase travelling alongside the multiplier latency
  typedef struct packed {
    logic       valid;
    logic [1:0] phase;
  } Tag;

endpackage

// File: rtl/fir_input_ctrl_if.sv
// Bundle between the sample/coefficient source, fir_input_ctrl and fir_datapath.
interface fir_input_ctrl_if;
  import fir_pkg::*;

  logic              push_in;
  Samp               samp_in;
  logic              stop_in;
  logic              coef_wr;
  logic [3:0]        coef_addr;
  Coef               coef_data;
  logic              coef_err;
  Samp [NTAPS-1:0]   samp;
  Coef [NCOEF-1:0]   coef;
  logic [1:0]        mux_sel;
  logic              partialProductAccumulate_valid;
  logic              finalAccumulateRounding_en;

  modport slave (
    input  push_in, samp_in, coef_wr, coef_addr, coef_data,
    output stop_in, coef_err, samp, coef, mux_sel,
           partialProductAccumulate_valid, finalAccumulateRounding_en
  );

  modport master (
    output push_in, samp_in, coef_wr, coef_addr, coef_data,
    input  stop_in, coef_err, samp, coef, mux_sel,
           partialProductAccumulate_valid, finalAccumulateRounding_en
  );

endinterface

// File: rtl/fir_delay_line.sv
// Sample delay line; entry 0 holds the newest sample, the oldest falls off the end.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_shift,
  input  Samp             i_samp,
  output Samp [NTAPS-1:0] o_line
);

  Samp [NTAPS-1:0] r_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line <= '0;
    end else if (i_shift) begin
      r_line <= {r_line[NTAPS-2:0], i_samp};
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/fir_input_ctrl.sv
// Front end of the FIR: sample intake with backpressure, coefficient bank and
// the three-phase MAC sequencer with its latency-matched enable pipeline.
module fir_input_ctrl
  import fir_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input logic            clk,
  input logic            reset,
  fir_input_ctrl_if.slave io_bus
);

  localparam int TAG_DEPTH = MULT_LAT + 2;

  Phase                 r_state;
  Phase                 w_nextState;
  logic                 w_stop;
  logic                 w_accept;
  logic [1:0]           w_muxSel;
  Tag                   w_issueTag;
  Tag [TAG_DEPTH-1:0]   r_tags;
  logic                 w_coefInRange;
  logic                 w_coefWrite;
  Coef [NCOEF-1:0]      r_coef;
  logic                 r_coefErr;

  assign w_stop   = (r_state == PH0) || (r_state == PH1);
  assign w_accept = io_bus.push_in && !w_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_muxSel    = 2'd0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = PH0;
      end
      PH0: begin
        w_muxSel    = 2'd0;
        w_nextState = PH1;
      end
      PH1: begin
        w_muxSel    = 2'd1;
        w_nextState = PH2;
      end
      PH2: begin
        w_muxSel    = 2'd2;
        w_nextState = w_accept ? PH0 : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Tags age one slot per cycle so each phase's enables line up with its product
  assign w_issueTag.valid = (r_state != IDLE);
  assign w_issueTag.phase = w_muxSel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tags <= '0;
    end else begin
      r_tags <= {r_tags[TAG_DEPTH-2:0], w_issueTag};
    end
  end

  assign w_coefInRange = io_bus.coef_addr < 4'(NCOEF);
  assign w_coefWrite   = io_bus.coef_wr && (r_state == IDLE) && w_coefInRange;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coef    <= '0;
      r_coefErr <= 1'b0;
    end else begin
      r_coefErr <= io_bus.coef_wr && !w_coefWrite;
      if (w_coefWrite) begin
        r_coef[io_bus.coef_addr] <= io_bus.coef_data;
      end
    end
  end

  fir_delay_line u_delayLine (
    .clk     (clk),
    .reset   (reset),
    .i_shift (w_accept),
    .i_samp  (io_bus.samp_in),
    .o_line  (io_bus.samp)
  );

  assign io_bus.stop_in  = w_stop;
  assign io_bus.mux_sel  = w_muxSel;
  assign io_bus.coef     = r_coef;
  assign io_bus.coef_err = r_coefErr;
  assign io_bus.partialProductAccumulate_valid =
    r_tags[MULT_LAT].valid && (r_tags[MULT_LAT].phase != 2'd0);
  assign io_bus.finalAccumulateRounding_en =
    r_tags[MULT_LAT+1].valid && (r_tags[MULT_LAT+1].phase == 2'd2);

endmodule

// File: tb/tb_fir_input_ctrl.sv
// Scoreboard bench for fir_input_ctrl: stimulus queues expected enable timing,
// a negedge monitor compares the datapath enables as they appear.
module tb_fir_input_ctrl;
  import fir_pkg::*;

  localparam int MULT_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   expFare[$];
  bit   expPpa[int];

  fir_input_ctrl_if bus ();

  fir_input_ctrl #(.MULT_LAT(MULT_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An accept during cycle a yields ppa 0,1,1 at a+4..a+6 and the final enable at a+7
  task automatic noteAccept(input int a);
    expPpa[a + 2 + MULT_LAT] = 1'b0;
    expPpa[a + 3 + MULT_LAT] = 1'b1;
    expPpa[a + 4 + MULT_LAT] = 1'b1;
    expFare.push_back(a + 5 + MULT_LAT);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("ppaValid", longint'(bus.partialProductAccumulate_valid),
                  expPpa.exists(cyc) ? longint'(expPpa[cyc]) : 64'sd0);
      if (bus.finalAccumulateRounding_en) begin
        if (expFare.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL fareUnexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          checkOutput("fareCycle", longint'(cyc), longint'(expFare.pop_front()));
        end
      end else if (expFare.size() != 0 && expFare[0] <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL fareMissing: no pulse at cycle %0d, expected one at %0d", cyc, expFare[0]);
        void'(expFare.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [3:0] addr, input Coef data,
                               input logic push, input Samp s);
    bus.coef_wr   = wr;
    bus.coef_addr = addr;
    bus.coef_data = data;
    bus.push_in   = push;
    bus.samp_in   = s;
    if (push && !bus.stop_in) noteAccept(cyc);
    tick();
    bus.coef_wr = 1'b0;
    bus.push_in = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (bus.stop_in && guard < 10) begin
      tick();
      guard++;
    end
    if (bus.stop_in) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: stop_in still 1 after %0d cycles, expected 0", guard);
    end
  endtask

  task automatic pushSample(input int vi, input int vq);
    Samp s;
    s.I = 24'(vi);
    s.Q = 24'(vq);
    waitIdle();
    applyStimulus(1'b0, 4'd0, '0, 1'b1, s);
  endtask

  task automatic coefWrite(input int addr, input int ci, input int cq);
    Coef c;
    c.I = 27'(ci);
    c.Q = 27'(cq);
    applyStimulus(1'b1, 4'(addr), c, 1'b0, '0);
  endtask

  // push_in stays high; a new value is presented each time stop_in drops
  task automatic pushHeld(input int n, input int base);
    int accepted = 0;
    int lastAcc  = -100;
    int guard    = 0;
    bus.push_in = 1'b1;
    while (accepted < n && guard < 400) begin
      if (!bus.stop_in) begin
        bus.samp_in.I = 24'(base + accepted);
        bus.samp_in.Q = '0;
        noteAccept(cyc);
        if (accepted > 0) checkOutput("acceptSpacing", longint'(cyc - lastAcc), 3);
        lastAcc = cyc;
        accepted++;
      end else begin
        checkOutput("stopAfterAccept", longint'(bus.stop_in), longint'((cyc - lastAcc) <= 2));
      end
      tick();
      guard++;
    end
    bus.push_in = 1'b0;
    if (accepted < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL pushHeld: accepted %0d samples, expected %0d", accepted, n);
    end
  endtask

  initial begin
    int a;
    Coef c;
    Samp s;

    reset         = 1'b1;
    bus.push_in   = 1'b0;
    bus.samp_in   = '0;
    bus.coef_wr   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstStop", longint'(bus.stop_in), 0);
    checkOutput("rstMux", longint'(bus.mux_sel), 0);
    checkOutput("rstCoefErr", longint'(bus.coef_err), 0);
    checkOutput("rstPpa", longint'(bus.partialProductAccumulate_valid), 0);
    checkOutput("rstFare", longint'(bus.finalAccumulateRounding_en), 0);
    checkOutput("rstSamp0", longint'($signed(bus.samp[0].I)), 0);
    checkOutput("rstSamp28", longint'($signed(bus.samp[28].Q)), 0);
    checkOutput("rstCoef14", longint'($signed(bus.coef[14].I)), 0);
    reset = 1'b0;
    tick();

    $display("[TB] single push");
    pushSample(32'h400000, 0);
    checkOutput("singleSamp0I", longint'($signed(bus.samp[0].I)), 64'h400000);
    checkOutput("singleSamp0Q", longint'($signed(bus.samp[0].Q)), 0);
    checkOutput("singleMuxPh0", longint'(bus.mux_sel), 0);
    checkOutput("singleStopPh0", longint'(bus.stop_in), 1);
    tick();
    checkOutput("singleMuxPh1", longint'(bus.mux_sel), 1);
    checkOutput("singleStopPh1", longint'(bus.stop_in), 1);
    tick();
    checkOutput("singleMuxPh2", longint'(bus.mux_sel), 2);
    checkOutput("singleStopPh2", longint'(bus.stop_in), 0);
    repeat (6) tick();
    checkOutput("singleIdleMux", longint'(bus.mux_sel), 0);
    checkOutput("singleIdleStop", longint'(bus.stop_in), 0);

    $display("[TB] reset mid-operation");
    pushSample(32'h400000, 0);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    expFare.delete();
    expPpa.delete();
    checkOutput("midRstPpa", longint'(bus.partialProductAccumulate_valid), 0);
    checkOutput("midRstFare", longint'(bus.finalAccumulateRounding_en), 0);
    checkOutput("midRstMux", longint'(bus.mux_sel), 0);
    checkOutput("midRstStop", longint'(bus.stop_in), 0);
    checkOutput("midRstSamp0", longint'($signed(bus.samp[0].I)), 0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    checkOutput("postRstSamp0", longint'($signed(bus.samp[0].I)), 0);

    $display("[TB] coefficient load");
    for (int k = 0; k < NCOEF; k++) begin
      coefWrite(k, k + 1, -(k + 1));
      checkOutput("coefLoadErr", longint'(bus.coef_err), 0);
    end
    checkOutput("coef14I", longint'($signed(bus.coef[14].I)), 15);
    checkOutput("coef14Q", longint'($signed(bus.coef[14].Q)), -15);
    checkOutput("coef0I", longint'($signed(bus.coef[0].I)), 1);
    coefWrite(15, 99, 99);
    checkOutput("addr15Err", longint'(bus.coef_err), 1);
    checkOutput("addr15Coef14", longint'($signed(bus.coef[14].I)), 15);
    checkOutput("addr15Coef0", longint'($signed(bus.coef[0].Q)), -1);
    tick();
    checkOutput("addr15ErrPulse", longint'(bus.coef_err), 0);

    $display("[TB] coefficient write while busy");
    pushSample(7, 0);
    tick();
    checkOutput("busyMuxPh1", longint'(bus.mux_sel), 1);
    coefWrite(3, 777, 777);
    checkOutput("busyErr", longint'(bus.coef_err), 1);
    checkOutput("busyCoef3I", longint'($signed(bus.coef[3].I)), 4);
    checkOutput("busyCoef3Q", longint'($signed(bus.coef[3].Q)), -4);
    repeat (8) tick();

    $display("[TB] coefficient write with push");
    c.I = -27'sd100;
    c.Q = 27'sd50;
    s.I = 24'h123456;
    s.Q = -24'sd5;
    waitIdle();
    a = cyc;
    applyStimulus(1'b1, 4'd2, c, 1'b1, s);
    checkOutput("bothCoef2I", longint'($signed(bus.coef[2].I)), -100);
    checkOutput("bothCoef2Q", longint'($signed(bus.coef[2].Q)), 50);
    checkOutput("bothSamp0I", longint'($signed(bus.samp[0].I)), 64'h123456);
    checkOutput("bothSamp0Q", longint'($signed(bus.samp[0].Q)), -5);
    checkOutput("bothStop", longint'(bus.stop_in), 1);
    checkOutput("bothAcceptCycle", longint'(cyc - a), 1);
    repeat (8) tick();
    checkOutput("bothErr", longint'(bus.coef_err), 0);

    $display("[TB] held push, 10 samples");
    pushHeld(10, 1);
    checkOutput("held10Samp0", longint'($signed(bus.samp[0].I)), 10);
    checkOutput("held10Samp9", longint'($signed(bus.samp[9].I)), 1);
    repeat (10) tick();

    $display("[TB] shift depth, 30 samples");
    pushHeld(30, 1);
    checkOutput("depthSamp0", longint'($signed(bus.samp[0].I)), 30);
    checkOutput("depthSamp27", longint'($signed(bus.samp[27].I)), 3);
    checkOutput("depthSamp28", longint'($signed(bus.samp[28].I)), 2);
    repeat (10) tick();

    checkOutput("fareQueueDrained", longint'(expFare.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
